// File: rtl/mac_pkg.sv
// Shared definitions for the sequential multiply-accumulate core.
// Holds the controller state encoding, default widths, and the derived
// width of the shift-add step counter.
package mac_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StAcc  = 2'd2
    } mac_state_e;

    localparam int unsigned MAC_WIDTH = 4;
    localparam int unsigned MAC_ACC_W = 8;
    // The counter must be able to hold the value WIDTH itself.
    localparam int unsigned MAC_CNT_W = $clog2(MAC_WIDTH + 1);

endpackage

// File: rtl/mac_shift_mul.sv
// Shift-add multiplier datapath for mac_seq_core.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   load_i        capture a_i/b_i, clear the partial product and count
//   step_i        perform one shift-add step
//   a_i, b_i      unsigned operands
//   partial_o     running partial product (2*Width bits, cannot overflow)
//   done_o        the step taken this cycle is the last one
module mac_shift_mul
    import mac_pkg::*;
#(
    parameter int unsigned Width = MAC_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    output logic [2*Width-1:0] partial_o,
    output logic               done_o
);

    localparam int unsigned CntW = $clog2(Width + 1);

    logic [Width-1:0]   a_q, a_d;
    logic [Width-1:0]   b_q, b_d;
    logic [2*Width-1:0] partial_q, partial_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*Width-1:0] a_ext;

    assign a_ext = {{Width{1'b0}}, a_q};

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        partial_d = partial_q;
        cnt_d     = cnt_q;
        if (load_i) begin
            a_d       = a_i;
            b_d       = b_i;
            partial_d = '0;
            cnt_d     = '0;
        end else if (step_i) begin
            // b_q is shifted each step, so bit 0 always holds multiplier bit cnt_q.
            if (b_q[0]) begin
                partial_d = partial_q + (a_ext << cnt_q);
            end
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            partial_q <= partial_d;
            cnt_q     <= cnt_d;
        end
    end

    assign partial_o = partial_q;
    // Flagged on the final step so the controller can leave MUL on that same edge.
    assign done_o    = step_i && (cnt_q == CntW'(Width - 1));

endmodule

// File: rtl/mac_seq_core.sv
// Sequential unsigned multiply-accumulate engine.
// Accepts an operand pair in IDLE, multiplies it over Width shift-add cycles,
// then adds the product into a wrapping accumulator with a sticky overflow.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   in_valid_i     operand pair valid; in_ready_o high only in IDLE
//   a_i, b_i       unsigned multiplicand / multiplier
//   acc_clr_i      clear accumulator and overflow (honoured only in IDLE)
//   out_valid_o    one-cycle pulse after each accumulator update
//   product_o      last completed product, held until the next completion
//   acc_o          running accumulator, modulo 2^AccW
//   overflow_o     sticky carry-out of the accumulator
module mac_seq_core
    import mac_pkg::*;
#(
    parameter int unsigned Width = MAC_WIDTH,
    parameter int unsigned AccW  = MAC_ACC_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [Width-1:0]   a_i,
    input  logic [Width-1:0]   b_i,
    input  logic               acc_clr_i,
    output logic               out_valid_o,
    output logic [2*Width-1:0] product_o,
    output logic [AccW-1:0]    acc_o,
    output logic               overflow_o
);

    mac_state_e         state_q;
    logic               out_valid_q;
    logic [2*Width-1:0] product_q;
    logic [AccW-1:0]    acc_q;
    logic               overflow_q;

    logic               load;
    logic               step;
    logic               mul_done;
    logic [2*Width-1:0] partial;
    logic [AccW:0]      sum;

    assign in_ready_o = (state_q == StIdle);
    assign load       = in_ready_o && in_valid_i;
    assign step       = (state_q == StMul);

    // Extra top bit captures the carry-out for the sticky overflow flag.
    assign sum = {1'b0, acc_q} + {{(AccW + 1 - 2 * Width){1'b0}}, partial};

    mac_shift_mul #(
        .Width (Width)
    ) u_shift_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load),
        .step_i    (step),
        .a_i       (a_i),
        .b_i       (b_i),
        .partial_o (partial),
        .done_o    (mul_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            product_q   <= '0;
            acc_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A clear together with an accept lets the new product land on zero.
                    if (acc_clr_i) begin
                        acc_q      <= '0;
                        overflow_q <= 1'b0;
                    end
                    if (in_valid_i) begin
                        state_q <= StMul;
                    end
                end
                StMul: begin
                    if (mul_done) begin
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    product_q   <= partial;
                    acc_q       <= sum[AccW-1:0];
                    overflow_q  <= overflow_q | sum[AccW];
                    out_valid_q <= 1'b1;
                    state_q     <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign product_o   = product_q;
    assign acc_o       = acc_q;
    assign overflow_o  = overflow_q;

endmodule
